// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its requester arbiter: opcodes, datapath widths, tag type.
package alu_pkg;

  localparam int unsigned ALU_DW   = 64;
  localparam int unsigned ALU_OPW  = 3;
  localparam int unsigned TAG_MAXW = 3;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'b010;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'b110;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'b111;

  // Widest requester ID (NREQ up to 8); the arbiter narrows it to $clog2(NREQ).
  typedef logic [TAG_MAXW-1:0] tag_t;

endpackage

// File: rtl/alu.sv
// Single-entry 64-bit ALU: registered result, valid/ready on both sides.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DW  = ALU_DW,
  parameter int unsigned OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  in1,
  input  logic [DW-1:0]  in2,
  input  logic [OPW-1:0] op,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [DW-1:0]  res,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [DW-1:0] res_d;

  // A stalled result blocks new input, so at most one op is ever held.
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    res_d = '0;
    unique case (op)
      OP_ADD:  res_d = in1 + in2;
      OP_SUB:  res_d = in1 - in2;
      OP_XOR:  res_d = in1 ^ in2;
      OP_AND:  res_d = in1 & in2;
      OP_OR:   res_d = in1 | in2;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      res       <= res_d;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod NREQ.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned TAGW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [TAGW-1:0] idx,
  output logic            any
);

  localparam logic [TAGW-1:0] Last = TAGW'(NREQ - 1);

  logic [TAGW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
      cand = (cand == Last) ? '0 : cand + 1'b1;
    end
    gnt = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin issue, tag-routed response.
// Optional ALU_ARB_STATS_EN adds per-requester grant counters and a stall counter.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = ALU_DW,
  parameter  int unsigned OPW  = ALU_OPW,
  localparam int unsigned TAGW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_in1,
  input  logic [NREQ*DW-1:0]  req_in2,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_res,
  output logic [DW-1:0]       alu_in1,
  output logic [DW-1:0]       alu_in2,
  output logic [OPW-1:0]      alu_op,
  output logic                alu_in_valid,
  input  logic                alu_in_ready,
  input  logic [DW-1:0]       alu_res,
  input  logic                alu_out_valid,
  output logic                alu_out_ready
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]  stat_grants,
  output logic [31:0]         stat_stall
`endif
);

  localparam logic [TAGW-1:0] Last = TAGW'(NREQ - 1);

  logic [TAGW-1:0] rr_ptr_q, tag_q, win_idx;
  logic [NREQ-1:0] win_gnt;
  logic            win_any;
  logic            accept;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign accept = !rst && win_any && alu_in_ready;

  always_comb begin
    alu_in_valid = !rst && win_any;
    alu_in1      = '0;
    alu_in2      = '0;
    alu_op       = '0;
    if (!rst) begin
      alu_in1 = req_in1[32'(win_idx)*DW +: DW];
      alu_in2 = req_in2[32'(win_idx)*DW +: DW];
      alu_op  = req_op[32'(win_idx)*OPW +: OPW];
    end
    req_ready = accept ? win_gnt : '0;
  end

  // Routing uses the tag of the op currently held in the ALU; a same-cycle accept
  // overwrites the tag on the same edge the ALU result register does.
  always_comb begin
    rsp_valid     = (!rst && alu_out_valid) ? (NREQ'(1) << tag_q) : '0;
    rsp_res       = rst ? '0 : alu_res;
    alu_out_ready = !rst && rsp_ready[tag_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      tag_q    <= win_idx;
      rr_ptr_q <= (win_idx == Last) ? '0 : win_idx + 1'b1;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][31:0] grants_q;
  logic [31:0]           stall_q;
  logic                  stall;

  assign stall       = (|req_valid) && !alu_in_ready;
  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;

  // Grant counters wrap; the stall counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept) grants_q[win_idx] <= grants_q[win_idx] + 32'd1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter with the real ALU behind it; directed scenarios then random traffic.
// Stat-counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned OPW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0]  req_in1, req_in2;
  logic [NREQ*OPW-1:0] req_op;
  logic [DW-1:0]       rsp_res, alu_in1, alu_in2, alu_res;
  logic [OPW-1:0]      alu_op;
  logic                alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*32-1:0]  stat_grants;
  logic [31:0]         stat_stall;
`endif

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_in1       (req_in1),
    .req_in2       (req_in2),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_res       (rsp_res),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_op        (alu_op),
    .alu_in_valid  (alu_in_valid),
    .alu_in_ready  (alu_in_ready),
    .alu_res       (alu_res),
    .alu_out_valid (alu_out_valid),
    .alu_out_ready (alu_out_ready)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_stall    (stat_stall)
`endif
  );

  alu #(.DW(DW), .OPW(OPW)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .in1       (alu_in1),
    .in2       (alu_in2),
    .op        (alu_op),
    .in_valid  (alu_in_valid),
    .in_ready  (alu_in_ready),
    .res       (alu_res),
    .out_valid (alu_out_valid),
    .out_ready (alu_out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pointer, at most one outstanding result, accept mask of last cycle.
  int              m_ptr;
  bit              m_pend;
  int              m_tag;
  logic [DW-1:0]   m_res;
  logic [NREQ-1:0] m_acc;
  int              m_grants[NREQ];
  int              m_stall;
  int              dut_rsp[NREQ];

  function automatic logic [DW-1:0] calc(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_op[k*OPW +: OPW] = op;
    req_in1[k*DW +: DW]  = a;
    req_in2[k*DW +: DW]  = b;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = 0;
    m_tag  = 0;
    m_res  = '0;
    m_acc  = '0;
    m_stall = 0;
    for (int k = 0; k < NREQ; k++) m_grants[k] = 0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_alu_in_valid", alu_in_valid, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Compare one cycle of DUT behaviour with the model, then advance the model across the edge.
  task automatic cycle();
    int w, k;
    bit any, inr, acc, ret;
    logic [NREQ-1:0] exp_rr, exp_rv;
    #1;
    any = |req_valid;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (w < 0 && req_valid[k]) w = k;
    end
    inr = !m_pend || rsp_ready[m_tag];
    acc = any && inr;
    exp_rr = '0;
    if (acc) exp_rr[w] = 1'b1;
    exp_rv = '0;
    if (m_pend) exp_rv[m_tag] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("alu_in_valid", alu_in_valid, any);
    if (m_pend) chk("rsp_res", rsp_res, m_res);
    if (any) begin
      chk("alu_in1", alu_in1, req_in1[w*DW +: DW]);
      chk("alu_op", alu_op, req_op[w*OPW +: OPW]);
    end
    for (int j = 0; j < NREQ; j++) if (rsp_valid[j] && rsp_ready[j]) dut_rsp[j]++;
    ret = m_pend && rsp_ready[m_tag];
    if (any && !inr) m_stall++;
    m_acc = exp_rr;
    if (acc) begin
      m_pend = 1;
      m_tag  = w;
      m_res  = calc(req_op[w*OPW +: OPW], req_in1[w*DW +: DW], req_in2[w*DW +: DW]);
      m_ptr  = (w + 1) % NREQ;
      m_grants[w]++;
    end else if (ret) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    req_valid = '1;
    rsp_ready = '1;
    req_in1   = '0;
    req_in2   = '0;
    req_op    = '0;
    for (int k = 0; k < NREQ; k++) dut_rsp[k] = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);
    req_valid = '0;

    // Single requester: ADD 5+7 from req1.
    set_req(1, OP_ADD, 64'd5, 64'd7);
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    chk("t1_rsp_valid", rsp_valid, 4'b0010);
    chk("t1_rsp_res", rsp_res, 64'd12);
    cycle();

    // All four valid, SUB 100-k, full throughput.
    do_reset(1);
    for (int k = 0; k < NREQ; k++) begin
      set_req(k, OP_SUB, 64'd100, 64'(k));
      dut_rsp[k] = 0;
    end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = '0;
      exp_g[i % NREQ] = 1'b1;
      chk("t2_grant_order", req_ready, exp_g);
      cycle();
    end
    req_valid = '0;
    cycle();
    for (int k = 0; k < NREQ; k++) chk("t2_rsp_count", 64'(dut_rsp[k]), 64'd2);
`ifdef ALU_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) chk("t6_grants", stat_grants[k*32 +: 32], 32'd2);
    chk("t6_stall_zero", stat_stall, 32'd0);
`endif

    // Back-pressure: req2's XOR result stalls for 5 cycles.
    set_req(2, OP_XOR, 64'hF0F0, 64'h0FF0);
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    cycle();
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_req_ready_low", req_ready, '0);
      chk("t3_rsp_res_held", rsp_res, 64'hFF00);
      cycle();
    end
    rsp_ready = '1;
    #1;
    chk("t3_resume_req3", req_ready, 4'b1000);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
`ifdef ALU_ARB_STATS_EN
    chk("t6_stall_count", stat_stall, 32'd5);
`endif

    // Grant stability: ALU held busy by req3's stalled result.
    set_req(3, OP_OR, 64'h1, 64'h2);
    req_valid = 4'b1000;
    rsp_ready = 4'b0111;
    cycle();
    set_req(0, OP_ADD, 64'hAAAA, 64'h1);
    set_req(1, OP_AND, 64'hBBBB, 64'hFF);
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req_valid = 4'b0011;
      #1;
      chk("t4_grant_held", alu_in1, 64'hAAAA);
      chk("t4_no_accept", req_ready, '0);
      cycle();
    end
    rsp_ready = '1;
    #1;
    chk("t4_accept_req0", req_ready, 4'b0001);
    cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    cycle();
    cycle();

    // Reset the cycle after accepting an AND.
    set_req(2, OP_AND, 64'hF0, 64'h3C);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    do_reset(1);
    cycle();
    chk("t5_no_rsp", rsp_valid, '0);
    req_valid = '1;
    #1;
    chk("t5_ptr_zero", req_ready, 4'b0001);
    cycle();
    req_valid = '0;
    cycle();
    cycle();

    // Random traffic honouring the hold-while-not-accepted rule.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!(req_valid[k] && !m_acc[k])) begin
          req_valid[k] = ($urandom_range(0, 9) < 6);
          case ($urandom_range(0, 4))
            0: req_op[k*OPW +: OPW] = OP_ADD;
            1: req_op[k*OPW +: OPW] = OP_SUB;
            2: req_op[k*OPW +: OPW] = OP_XOR;
            3: req_op[k*OPW +: OPW] = OP_AND;
            default: req_op[k*OPW +: OPW] = OP_OR;
          endcase
          req_in1[k*DW +: DW] = {$urandom, $urandom};
          req_in2[k*DW +: DW] = {$urandom, $urandom};
        end
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    cycle();
    cycle();
`ifdef ALU_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) chk("rand_grants", stat_grants[k*32 +: 32], 32'(m_grants[k]));
    chk("rand_stall", stat_stall, 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
